// File: rtl/operand_read_pkg.sv
// Shared types for the physical register file, rename and write-back paths.
package operand_read_pkg;

   localparam int PREG_W     = 7;
   localparam int XLEN       = 32;
   localparam int PREG_COUNT = 128;

   typedef struct packed {
      logic [PREG_W-1:0] addr;
      logic [XLEN-1:0]   data;
   } RESULT;

   typedef struct packed {
      logic [PREG_W-1:0] src1;
      logic [PREG_W-1:0] src2;
   } OPERAND_REQ;

   typedef struct packed {
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
   } OPERAND_RESP;

endpackage

// File: rtl/preg_scoreboard.sv
// Busy-bit scoreboard for physical registers.
// Produces per-source readiness, including same-cycle write-back bypass.
module preg_scoreboard import operand_read_pkg::*; #(
   parameter int M          = 2,
   parameter int PREG_COUNT = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alloc_valid,
   input  logic [PREG_W-1:0]     alloc_addr,
   input  logic [PREG_W-1:0]     write_addr,
   input  OPERAND_REQ [M-1:0]    req,
   output logic [M-1:0]          src1_ready,
   output logic [M-1:0]          src2_ready,
   output logic [M-1:0]          src1_bypass,
   output logic [M-1:0]          src2_bypass
);

   logic [PREG_COUNT-1:0] busy;

   // Alloc is applied after the write so it wins on a same-tag collision.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy <= '0;
      end else begin
         if (write_addr != '0)
            busy[write_addr] <= 1'b0;
         if (alloc_valid && alloc_addr != '0)
            busy[alloc_addr] <= 1'b1;
      end
   end

   for (genvar p = 0; p < M; p++) begin : g_lookup
      assign src1_bypass[p] = (req[p].src1 != '0) && (req[p].src1 == write_addr);
      assign src2_bypass[p] = (req[p].src2 != '0) && (req[p].src2 == write_addr);
      assign src1_ready[p]  = (req[p].src1 == '0) || !busy[req[p].src1] || src1_bypass[p];
      assign src2_ready[p]  = (req[p].src2 == '0) || !busy[req[p].src2] || src2_bypass[p];
   end

endmodule

// File: rtl/operand_read.sv
// Physical register file with M independent two-source operand read ports.
// Each port has a 1-entry response buffer under valid/ready handshakes.
module operand_read import operand_read_pkg::*; #(
   parameter int M          = 2,
   parameter int PREG_COUNT = 128
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [PREG_W-1:0]          write_addr,
   input  logic [XLEN-1:0]            write_data,
   input  logic                       alloc_valid,
   input  logic [PREG_W-1:0]          alloc_addr,
   input  logic [M-1:0]               req_valid,
   output logic [M-1:0]               req_ready,
   input  logic [M-1:0][PREG_W-1:0]   req_src1,
   input  logic [M-1:0][PREG_W-1:0]   req_src2,
   output logic [M-1:0]               resp_valid,
   input  logic [M-1:0]               resp_ready,
   output logic [M-1:0][XLEN-1:0]     resp_op1,
   output logic [M-1:0][XLEN-1:0]     resp_op2
);

   OPERAND_REQ [M-1:0] req;
   logic [M-1:0]       s1_rdy, s2_rdy, s1_byp, s2_byp;
   logic [XLEN-1:0]    rf [PREG_COUNT];

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PREG_COUNT; i++) rf[i] <= '0;
      end else if (write_addr != '0) begin
         rf[write_addr] <= write_data;
      end
   end

   preg_scoreboard #(.M(M), .PREG_COUNT(PREG_COUNT)) u_sb (
      .clk         (clk),
      .reset       (reset),
      .alloc_valid (alloc_valid),
      .alloc_addr  (alloc_addr),
      .write_addr  (write_addr),
      .req         (req),
      .src1_ready  (s1_rdy),
      .src2_ready  (s2_rdy),
      .src1_bypass (s1_byp),
      .src2_bypass (s2_byp)
   );

   for (genvar p = 0; p < M; p++) begin : g_port
      logic        v;
      OPERAND_RESP q;
      OPERAND_RESP rd;

      assign req[p].src1 = req_src1[p];
      assign req[p].src2 = req_src2[p];
      assign rd.op1      = s1_byp[p] ? write_data : rf[req_src1[p]];
      assign rd.op2      = s2_byp[p] ? write_data : rf[req_src2[p]];

      // No dependence on req_valid keeps the issue-side handshake loop-free.
      assign req_ready[p] = s1_rdy[p] & s2_rdy[p] & (!v | resp_ready[p]);

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            v <= 1'b0;
            q <= '0;
         end else if (req_valid[p] && req_ready[p]) begin
            v <= 1'b1;
            q <= rd;
         end else if (resp_ready[p]) begin
            v <= 1'b0;
         end
      end

      assign resp_valid[p] = v;
      assign resp_op1[p]   = v ? q.op1 : '0;
      assign resp_op2[p]   = v ? q.op2 : '0;
   end

endmodule

// File: tb/tb_operand_read.sv
// Directed bench for operand_read: a tag-level reference model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_operand_read;
   localparam int M = 2;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [6:0]           write_addr;
   logic [31:0]          write_data;
   logic                 alloc_valid;
   logic [6:0]           alloc_addr;
   logic [M-1:0]         req_valid;
   logic [M-1:0]         req_ready;
   logic [M-1:0][6:0]    req_src1, req_src2;
   logic [M-1:0]         resp_valid;
   logic [M-1:0]         resp_ready;
   logic [M-1:0][31:0]   resp_op1, resp_op2;

   int checks = 0;
   int errors = 0;

   operand_read #(.M(M), .PREG_COUNT(128)) dut (
      .clk(clk), .reset(reset),
      .write_addr(write_addr), .write_data(write_data),
      .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src1(req_src1), .req_src2(req_src2),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_op1(resp_op1), .resp_op2(resp_op2)
   );

   always #5 clk = ~clk;

   // Reference model: register values, pending-producer set, held responses.
   bit          busy_m [128];
   logic [31:0] rf_m   [128];
   bit          rv_m   [M];
   logic [31:0] o1_m   [M];
   logic [31:0] o2_m   [M];

   function automatic bit src_ok(logic [6:0] t);
      return (t == 0) || !busy_m[t] || (write_addr == t);
   endfunction

   function automatic logic [31:0] src_val(logic [6:0] t);
      if (t == 0) return 32'h0;
      if (write_addr == t) return write_data;
      return rf_m[t];
   endfunction

   function automatic bit exp_rdy(int p);
      return src_ok(req_src1[p]) && src_ok(req_src2[p]) && (!rv_m[p] || resp_ready[p]);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 128; i++) begin busy_m[i] = 0; rf_m[i] = 0; end
         for (int p = 0; p < M; p++) begin rv_m[p] = 0; o1_m[p] = 0; o2_m[p] = 0; end
      end else begin
         for (int p = 0; p < M; p++) begin
            if (req_valid[p] && exp_rdy(p)) begin
               rv_m[p] = 1;
               o1_m[p] = src_val(req_src1[p]);
               o2_m[p] = src_val(req_src2[p]);
            end else if (resp_ready[p]) begin
               rv_m[p] = 0;
            end
         end
         if (write_addr != 0) begin
            rf_m[write_addr]   = write_data;
            busy_m[write_addr] = 0;
         end
         if (alloc_valid && alloc_addr != 0) busy_m[alloc_addr] = 1;
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int p = 0; p < M; p++) begin
         if (!reset) begin
            chk($sformatf("rst_resp_valid[%0d]", p), resp_valid[p], 0);
         end else begin
            chk($sformatf("req_ready[%0d]", p),  req_ready[p],  exp_rdy(p));
            chk($sformatf("resp_valid[%0d]", p), resp_valid[p], rv_m[p]);
            chk($sformatf("resp_op1[%0d]", p),   resp_op1[p],   rv_m[p] ? o1_m[p] : 32'h0);
            chk($sformatf("resp_op2[%0d]", p),   resp_op2[p],   rv_m[p] ? o2_m[p] : 32'h0);
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      write_addr = 0; write_data = 0; alloc_valid = 0; alloc_addr = 0;
      req_valid = '0; req_src1 = '0; req_src2 = '0; resp_ready = '1;

      // Reset state
      repeat (2) step();
      @(negedge clk); chk("lit_reset_valid", resp_valid, 0);
      step(); reset = 1;

      // Plain read of an untouched tag and tag 0
      req_valid[0] = 1; req_src1[0] = 5; req_src2[0] = 0;
      @(negedge clk); chk("lit_first_ready", req_ready[0], 1);
      step(); req_valid[0] = 0;
      @(negedge clk); chk("lit_first_valid", resp_valid[0], 1); chk("lit_first_op1", resp_op1[0], 0);

      // Alloc then stall, released by write-back bypass
      step(); alloc_valid = 1; alloc_addr = 9;
      step(); alloc_valid = 0; req_valid[0] = 1; req_src1[0] = 9;
      @(negedge clk); chk("lit_busy_stall", req_ready[0], 0);
      step(); write_addr = 9; write_data = 32'hDEADBEEF;
      @(negedge clk); chk("lit_bypass_ready", req_ready[0], 1);
      step(); write_addr = 0; req_valid[0] = 0;
      @(negedge clk); chk("lit_bypass_op1", resp_op1[0], 32'hDEADBEEF);

      // Array read, backpressure, then resumption at one per cycle
      step(); write_addr = 12; write_data = 32'h1234;
      step(); write_addr = 0; req_valid[1] = 1; req_src1[1] = 0; req_src2[1] = 12; resp_ready[1] = 0;
      @(negedge clk); chk("lit_p1_ready", req_ready[1], 1);
      step();
      repeat (3) begin
         @(negedge clk);
         chk("lit_hold_op2", resp_op2[1], 32'h1234);
         chk("lit_hold_ready", req_ready[1], 0);
         step();
      end
      resp_ready[1] = 1;
      @(negedge clk); chk("lit_resume_ready", req_ready[1], 1);
      step(); req_src2[1] = 9;
      @(negedge clk); chk("lit_resume_op2", resp_op2[1], 32'h1234); chk("lit_resume_valid", resp_valid[1], 1);
      step(); req_valid[1] = 0;
      @(negedge clk); chk("lit_next_op2", resp_op2[1], 32'hDEADBEEF);
      step();

      // Same-cycle alloc and write on one tag: busy wins, data stored
      alloc_valid = 1; alloc_addr = 20; write_addr = 20; write_data = 32'h55;
      step(); alloc_valid = 0; write_addr = 0; req_valid[0] = 1; req_src1[0] = 20; req_src2[0] = 0;
      @(negedge clk); chk("lit_collide_stall", req_ready[0], 0); chk("lit_collide_data", dut.rf[20], 32'h55);
      step(); write_addr = 20; write_data = 32'h66;
      @(negedge clk); chk("lit_collide_release", req_ready[0], 1);
      step(); write_addr = 0; req_valid[0] = 0;
      @(negedge clk); chk("lit_collide_op1", resp_op1[0], 32'h66);

      // Write to tag 0 is ignored
      step(); write_addr = 0; write_data = 32'hFFFF; req_valid[0] = 1; req_src1[0] = 0; req_src2[0] = 0;
      @(negedge clk); chk("lit_tag0_ready", req_ready[0], 1);
      step(); req_valid[0] = 0; write_data = 0;
      @(negedge clk); chk("lit_tag0_op1", resp_op1[0], 0); chk("lit_tag0_op2", resp_op2[0], 0);

      // Async reset while both ports hold responses
      step(); alloc_valid = 1; alloc_addr = 20; resp_ready = '0; req_valid = '1;
      req_src1[0] = 12; req_src1[1] = 9; req_src2 = '0;
      step(); alloc_valid = 0;
      @(negedge clk); chk("lit_both_valid", resp_valid, 2'b11);
      #1 reset = 0;
      #1 chk("lit_async_valid", resp_valid, 0); chk("lit_async_op1", resp_op1[1], 0);
      step(); step(); reset = 1; req_src1[0] = 20; resp_ready = '1;
      @(negedge clk); chk("lit_post_reset_ready", req_ready, 2'b11);
      step(); req_valid = '0;
      @(negedge clk); chk("lit_post_reset_valid", resp_valid, 2'b11);
      chk("lit_post_reset_op1_0", resp_op1[0], 0); chk("lit_post_reset_op1_1", resp_op1[1], 0);
      repeat (2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/operand_read.md
# operand_read

Physical register file plus readiness scoreboard that sits on the far side of the write-back stage. It absorbs the single `write_addr`/`write_data` port that write-back drives each cycle, and tracks which physical registers are still awaiting a producer. It serves M issue-side operand read ports, each fetching two source operands under a valid/ready handshake. A request is only accepted once both of its sources are ready, either from the scoreboard or by same-cycle bypass.

## Interface
- `M`, default 2: number of operand read ports.
- `PREG_COUNT`, default 128: physical registers; tag width is `$clog2(PREG_COUNT)` = 7.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low (`clk`, `reset`).
- `write_addr` in 7: write-back destination tag; 0 = no write this cycle.
- `write_data` in 32: write-back data, qualified by `write_addr != 0`.
- `alloc_valid` in 1: rename allocated a destination this cycle.
- `alloc_addr` in 7: tag to mark busy; 0 is ignored.
- `req_valid` in [M]: operand request per port.
- `req_ready` out [M]: request accepted when `req_valid & req_ready`.
- `req_src1`, `req_src2` in [M][7]: source tags; tag 0 reads constant 0.
- `resp_valid` out [M]: response holding two operands.
- `resp_ready` in [M]: consumer takes the response.
- `resp_op1`, `resp_op2` out [M][32]: operand data.

## Operation
- Storage: 128×32 flops; entry 0 is hard-wired 0 and never written.
- Scoreboard: one busy bit per tag.
  - `alloc_valid` with a nonzero tag sets busy at the next edge.
  - A write with nonzero `write_addr` clears busy and stores data at the next edge.
  - Alloc and write to the same tag in the same cycle: alloc wins (busy set), data still stored.
- Source ready when any of these holds:
  - tag == 0;
  - busy bit clear;
  - `write_addr == tag` this cycle (bypass).
- Operand value selection: bypass `write_data` when `write_addr == tag != 0`; otherwise array contents.
- Per port, `req_ready = src1_ready & src2_ready & (!resp_valid | resp_ready)`, combinational. There is no cross-port arbitration; every port reads independently.
- On accept, operands are captured into that port's response register. `resp_valid` is set at the next edge.
- Response register per port acts as a 1-entry buffer:
  - Holds its contents stably while `resp_valid & !resp_ready`.
  - Clears `resp_valid` on `resp_ready` unless a new accept occurs in the same cycle.
  - Back-to-back accepts give one response per cycle.
- A later write to a source tag never alters a captured response.
- `resp_op1`/`resp_op2` are zero whenever `resp_valid` is low.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) sets:
  - all busy bits = 0;
  - all data = 0;
  - `resp_valid` = 0, `resp_op*` = 0.
  - `req_ready` then follows its equation (1 for any request).
- Reset mid-transaction discards held responses; no partial state survives.
- Read latency: accept at edge N gives `resp_valid` high after edge N.
- Write to read-visibility:
  - Same cycle via bypass.
  - Array visible from the cycle after the write.
- Alloc to busy: a request in the alloc cycle still sees the old busy state. Busy is visible from the next cycle.
- `req_ready` must not depend on `req_valid` (no combinational loop with the issue stage).

## Structure
- Shared package gains:
  - `PREG_W = 7`, `XLEN = 32`, `PREG_COUNT = 128`;
  - typedef `OPERAND_REQ` {src1, src2};
  - typedef `OPERAND_RESP` {op1, op2}.
  - The existing `RESULT` typedef stays unchanged.
- One sub-module, `preg_scoreboard`: busy-bit vector with alloc/write update and M×2 combinational ready lookups with bypass.
- Data array and response buffers live in `operand_read`.

## Test plan
- Reset, then request src1=5, src2=0 on port 0 → `req_ready`=1, next cycle `resp_valid`=1, op1=0, op2=0.
- Alloc 9; next cycle request src1=9 → `req_ready`=0. Write 9/0xDEADBEEF with request held → accepted that cycle, op1=0xDEADBEEF (bypass).
- Write 12/0x1234; next cycle port 1 reads src2=12 → op2=0x1234. Hold `resp_ready`=0 for 3 cycles with a new request pending → response stable, `req_ready`=0. Raise `resp_ready` → pipeline resumes 1/cycle.
- Same-cycle alloc 20 and write 20/0x55 → busy; a request for 20 next cycle stalls; array holds 0x55.
- Write `write_addr`=0 with `write_data`=0xFFFF → read of tag 0 still returns 0; no busy bit changes.
- Assert reset with `resp_valid`=1 on both ports → `resp_valid`=0 immediately (async); after release all tags ready and read 0.
